extract_struct: RTL



---
 rtl/extract_struct.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/extract_struct.sv
// Splits a fixed-size struct off the head of a buffer AXI stream and forwards
// the remaining payload re-aligned to byte 0. Optional macro: EXTRACT_RUNT_DROP_EN.
module extract_struct #(
    parameter int BUF_DATA_WIDTH = 256,
    parameter int BUF_KEEP_WIDTH = BUF_DATA_WIDTH / 8,
    parameter int STRUCT_WIDTH   = 112
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [BUF_DATA_WIDTH-1:0] s_inbuf_axis_tdata,
    input  logic [BUF_KEEP_WIDTH-1:0] s_inbuf_axis_tkeep,
    input  logic                      s_inbuf_axis_tvalid,
    output logic                      s_inbuf_axis_tready,
    input  logic                      s_inbuf_axis_tlast,

    output logic [STRUCT_WIDTH-1:0]   m_struct_axis_tdata,
    output logic                      m_struct_axis_tvalid,
    input  logic                      m_struct_axis_tready,

    output logic [BUF_DATA_WIDTH-1:0] m_outbuf_axis_tdata,
    output logic [BUF_KEEP_WIDTH-1:0] m_outbuf_axis_tkeep,
    output logic                      m_outbuf_axis_tvalid,
    input  logic                      m_outbuf_axis_tready,
    output logic                      m_outbuf_axis_tlast,

    output logic [15:0]               runt_drop_count
);

    localparam int N         = BUF_KEEP_WIDTH;
    localparam int S         = STRUCT_WIDTH / 8;
    localparam int SHIFT_IN  = 8 * S;
    localparam int SHIFT_RES = 8 * (N - S);
    localparam int CW        = $clog2(N + 1);
    localparam logic [CW-1:0] S_CNT = CW'(S);

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        FLUSH
    } state_t;

    state_t state_q, state_d;

    // Output and residue registers
    logic [STRUCT_WIDTH-1:0]   st_data_q;
    logic                      st_valid_q;
    logic [BUF_DATA_WIDTH-1:0] ob_data_q;
    logic [BUF_KEEP_WIDTH-1:0] ob_keep_q;
    logic                      ob_valid_q;
    logic                      ob_last_q;
    // Residue is kept full-width so S = N needs no zero-width special case;
    // its upper S bytes are always zero.
    logic [BUF_DATA_WIDTH-1:0] res_data_q;
    logic [BUF_KEEP_WIDTH-1:0] res_keep_q;

    logic st_free, ob_free, in_ready, in_fire;
    logic load_struct, load_out, load_res;
    logic [BUF_DATA_WIDTH-1:0] ob_data_d;
    logic [BUF_KEEP_WIDTH-1:0] ob_keep_d;
    logic                      ob_last_d;
    logic [BUF_DATA_WIDTH-1:0] in_masked;
    logic [CW-1:0]             in_count;

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + CW'(k[i]);
        return c;
    endfunction

    // Bytes outside tkeep are zeroed so the struct and re-aligned payload never
    // carry stale upstream data.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            in_masked[8*i +: 8] = s_inbuf_axis_tkeep[i] ? s_inbuf_axis_tdata[8*i +: 8] : 8'h00;
        end
    end

    assign in_count = popcount(s_inbuf_axis_tkeep);
    assign st_free  = !st_valid_q || m_struct_axis_tready;
    assign ob_free  = !ob_valid_q || m_outbuf_axis_tready;

    // Ready depends only on state and output-slot status, never on tvalid.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            HEAD:    in_ready = st_free && ob_free;
            BODY:    in_ready = ob_free;
            default: in_ready = 1'b0;
        endcase
        if (rst) in_ready = 1'b0;
    end

    assign in_fire             = s_inbuf_axis_tvalid && in_ready;
    assign s_inbuf_axis_tready = in_ready;

`ifdef EXTRACT_RUNT_DROP_EN
    logic drop_runt;
    logic runt;
    assign runt = s_inbuf_axis_tlast && (in_count < S_CNT);
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        load_struct = 1'b0;
        load_out    = 1'b0;
        load_res    = 1'b0;
        ob_data_d   = '0;
        ob_keep_d   = '0;
        ob_last_d   = 1'b0;
`ifdef EXTRACT_RUNT_DROP_EN
        drop_runt   = 1'b0;
`endif
        case (state_q)
            HEAD: begin
                if (in_fire) begin
`ifdef EXTRACT_RUNT_DROP_EN
                    if (runt) begin
                        drop_runt = 1'b1;
                    end else
`endif
                    begin
                        load_struct = 1'b1;
                        if (s_inbuf_axis_tlast) begin
                            // Zero-keep last beat is still emitted so every packet
                            // produces a buffer beat with tlast.
                            load_out  = 1'b1;
                            ob_data_d = in_masked >> SHIFT_IN;
                            ob_keep_d = s_inbuf_axis_tkeep >> S;
                            ob_last_d = 1'b1;
                        end else begin
                            load_res = 1'b1;
                            state_d  = BODY;
                        end
                    end
                end
            end
            BODY: begin
                if (in_fire) begin
                    load_out  = 1'b1;
                    ob_data_d = res_data_q | (in_masked << SHIFT_RES);
                    ob_keep_d = res_keep_q | (s_inbuf_axis_tkeep << (N - S));
                    if (s_inbuf_axis_tlast) begin
                        if (in_count > S_CNT) begin
                            ob_last_d = 1'b0;
                            load_res  = 1'b1;
                            state_d   = FLUSH;
                        end else begin
                            ob_last_d = 1'b1;
                            state_d   = HEAD;
                        end
                    end else begin
                        load_res = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (ob_free) begin
                    load_out  = 1'b1;
                    ob_data_d = res_data_q;
                    ob_keep_d = res_keep_q;
                    ob_last_d = 1'b1;
                    state_d   = HEAD;
                end
            end
            default: state_d = HEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state_q <= HEAD;
        else     state_q <= state_d;
    end

    // NOTE: data and keep registers are reset too, so outputs read as zero
    // during reset rather than holding whatever the last packet left.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_data_q  <= '0;
            st_valid_q <= 1'b0;
        end else if (load_struct) begin
            st_data_q  <= in_masked[STRUCT_WIDTH-1:0];
            st_valid_q <= 1'b1;
        end else if (m_struct_axis_tready) begin
            st_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ob_data_q  <= '0;
            ob_keep_q  <= '0;
            ob_last_q  <= 1'b0;
            ob_valid_q <= 1'b0;
        end else if (load_out) begin
            ob_data_q  <= ob_data_d;
            ob_keep_q  <= ob_keep_d;
            ob_last_q  <= ob_last_d;
            ob_valid_q <= 1'b1;
        end else if (m_outbuf_axis_tready) begin
            ob_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q <= '0;
            res_keep_q <= '0;
        end else if (load_res) begin
            res_data_q <= in_masked >> SHIFT_IN;
            res_keep_q <= s_inbuf_axis_tkeep >> S;
        end
    end

`ifdef EXTRACT_RUNT_DROP_EN
    logic [15:0] runt_cnt_q;
    always_ff @(posedge clk) begin
        if (rst)                                    runt_cnt_q <= '0;
        else if (drop_runt && runt_cnt_q != 16'hFFFF) runt_cnt_q <= runt_cnt_q + 16'd1;
    end
    assign runt_drop_count = runt_cnt_q;
`else
    assign runt_drop_count = '0;
`endif

    assign m_struct_axis_tdata  = st_data_q;
    assign m_struct_axis_tvalid = st_valid_q;
    assign m_outbuf_axis_tdata  = ob_data_q;
    assign m_outbuf_axis_tkeep  = ob_keep_q;
    assign m_outbuf_axis_tvalid = ob_valid_q;
    assign m_outbuf_axis_tlast  = ob_last_q;

endmodule
